// File: rtl/johnson_checker_if.sv
// Bus between a Johnson-code source and the johnson_checker monitor.
interface johnson_checker_if #(
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned IW = $clog2(2 * WIDTH);

  logic [WIDTH-1:0] code_in;
  logic             valid_in;
  logic [IW-1:0]    index;
  logic             index_valid;
  logic             locked;
  logic             err_code;
  logic             err_seq;
  logic [7:0]       err_count;

  // Source side: presents code words, observes checker status.
  modport master (
    output code_in, valid_in,
    input  index, index_valid, locked, err_code, err_seq, err_count
  );

  // Checker side: samples code words, reports status.
  modport slave (
    input  code_in, valid_in,
    output index, index_valid, locked, err_code, err_seq, err_count
  );
endinterface

// File: rtl/johnson_checker.sv
// Receive-side checker for a WIDTH-bit Johnson counter: decodes the code to a
// state index, flags illegal words and out-of-sequence steps, tracks lock and
// keeps a saturating error count.
module johnson_checker #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LOCK_CNT = 2
) (
  input logic              clk,
  input logic              rst_n,
  johnson_checker_if.slave bus
);
  localparam int unsigned IW = $clog2(2 * WIDTH);
  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK    = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] prev, prev_nxt;
  logic [MW-1:0]    mcnt, mcnt_nxt;

  logic [IW-1:0]    index_q, index_nxt;
  logic             index_valid_q, index_valid_nxt;
  logic             locked_q, locked_nxt;
  logic             err_code_q, err_code_nxt;
  logic             err_seq_q, err_seq_nxt;
  logic [CW-1:0]    err_count_q, err_count_nxt;

  logic             legal;
  logic             match;
  logic [IW-1:0]    decoded;

  // Next code word in the twisted-ring sequence.
  function automatic logic [WIDTH-1:0] succ(input logic [WIDTH-1:0] c);
    return {~c[0], c[WIDTH-1:1]};
  endfunction

  // Legal Johnson words have at most one boundary between adjacent bits.
  function automatic logic is_legal(input logic [WIDTH-1:0] c);
    int unsigned edges;
    edges = 0;
    for (int i = 0; i < int'(WIDTH) - 1; i++) begin
      if (c[i] != c[i+1]) edges++;
    end
    return (edges <= 1);
  endfunction

  // Ones count gives the index on the filling half; the draining half
  // (MSB clear, not all-zero) counts back down from 2*WIDTH.
  function automatic logic [IW-1:0] decode(input logic [WIDTH-1:0] c);
    int unsigned p;
    p = 0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (c[i]) p++;
    end
    if (c[WIDTH-1] || (c == '0)) return IW'(p);
    return IW'(2 * WIDTH - p);
  endfunction

  // Classify the incoming word.
  always_comb begin
    legal   = is_legal(bus.code_in);
    match   = (bus.code_in == succ(prev));
    decoded = decode(bus.code_in);
  end

  // State register together with the tracked code and match count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= UNLOCKED;
      prev  <= '0;
      mcnt  <= '0;
    end else begin
      state <= state_nxt;
      prev  <= prev_nxt;
      mcnt  <= mcnt_nxt;
    end
  end

  // Next-state logic; an illegal word always drops back to UNLOCKED.
  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    mcnt_nxt  = mcnt;
    if (bus.valid_in) begin
      if (!legal) begin
        state_nxt = UNLOCKED;
        mcnt_nxt  = '0;
      end else begin
        prev_nxt = bus.code_in;
        case (state)
          UNLOCKED: begin
            mcnt_nxt  = '0;
            state_nxt = CHECK;
          end
          CHECK: begin
            if (match) begin
              mcnt_nxt = mcnt + MW'(1);
              if ((mcnt + MW'(1)) == MW'(LOCK_CNT)) state_nxt = LOCKED;
            end else begin
              mcnt_nxt = '0;
            end
          end
          LOCKED: begin
            if (!match) begin
              mcnt_nxt  = '0;
              state_nxt = CHECK;
            end
          end
          default: begin
            mcnt_nxt  = '0;
            state_nxt = UNLOCKED;
          end
        endcase
      end
    end
  end

  // Output next values; at most one error event per sample.
  always_comb begin
    index_nxt       = index_q;
    index_valid_nxt = 1'b0;
    err_code_nxt    = 1'b0;
    err_seq_nxt     = 1'b0;
    err_count_nxt   = err_count_q;
    locked_nxt      = (state_nxt == LOCKED);
    if (bus.valid_in) begin
      if (legal) begin
        index_nxt       = decoded;
        index_valid_nxt = 1'b1;
        err_seq_nxt     = (state != UNLOCKED) && !match;
      end else begin
        err_code_nxt = 1'b1;
      end
    end
    if ((err_code_nxt || err_seq_nxt) && (err_count_q != CNT_MAX)) begin
      err_count_nxt = err_count_q + CW'(1);
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q       <= '0;
      index_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      err_code_q    <= 1'b0;
      err_seq_q     <= 1'b0;
      err_count_q   <= '0;
    end else begin
      index_q       <= index_nxt;
      index_valid_q <= index_valid_nxt;
      locked_q      <= locked_nxt;
      err_code_q    <= err_code_nxt;
      err_seq_q     <= err_seq_nxt;
      err_count_q   <= err_count_nxt;
    end
  end

  assign bus.index       = index_q;
  assign bus.index_valid = index_valid_q;
  assign bus.locked      = locked_q;
  assign bus.err_code    = err_code_q;
  assign bus.err_seq     = err_seq_q;
  assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_johnson_checker.sv
// Self-checking bench for johnson_checker (WIDTH=4, LOCK_CNT=2).
module tb_johnson_checker;
  localparam int unsigned WIDTH = 4;

  typedef struct {
    logic       valid;
    logic [3:0] code;
    int         idx;
    int         iv;
    int         lk;
    int         ec;
    int         es;
    int         cnt;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  vec_t sb[$];
  vec_t vecs[28];

  johnson_checker_if #(.WIDTH(WIDTH)) bus ();

  johnson_checker #(.WIDTH(WIDTH), .LOCK_CNT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [3:0] c, input int idx,
                              input int iv, input int lk, input int ec,
                              input int es, input int cnt);
    vec_t r;
    r.valid = v; r.code = c; r.idx = idx; r.iv = iv;
    r.lk = lk; r.ec = ec; r.es = es; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input vec_t e);
    chk({tag, ".index"},       int'(bus.index),       e.idx);
    chk({tag, ".index_valid"}, int'(bus.index_valid), e.iv);
    chk({tag, ".locked"},      int'(bus.locked),      e.lk);
    chk({tag, ".err_code"},    int'(bus.err_code),    e.ec);
    chk({tag, ".err_seq"},     int'(bus.err_seq),     e.es);
    chk({tag, ".err_count"},   int'(bus.err_count),   e.cnt);
  endtask

  // Drive one sample, queue its expectation, compare after the edge.
  task automatic step(input string tag, input vec_t v);
    vec_t e;
    bus.valid_in = v.valid;
    bus.code_in  = v.code;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s scoreboard empty actual=0 required=1", tag);
    end else begin
      e = sb.pop_front();
      check_all(tag, e);
    end
  endtask

  initial begin
    logic [3:0] bad[8];
    int         exp_cnt;
    n_checks = 0;
    n_fail   = 0;
    bad[0] = 4'b0101; bad[1] = 4'b1010; bad[2] = 4'b1001; bad[3] = 4'b0110;
    bad[4] = 4'b1011; bad[5] = 4'b1101; bad[6] = 4'b0100; bad[7] = 4'b0010;

    //             v   code     idx iv lk ec es cnt
    vecs[0]  = mk(1, 4'b0000, 0, 1, 0, 0, 0, 0);
    vecs[1]  = mk(1, 4'b1000, 1, 1, 0, 0, 0, 0);
    vecs[2]  = mk(1, 4'b1100, 2, 1, 1, 0, 0, 0);
    vecs[3]  = mk(1, 4'b1110, 3, 1, 1, 0, 0, 0);
    vecs[4]  = mk(1, 4'b1111, 4, 1, 1, 0, 0, 0);
    vecs[5]  = mk(1, 4'b0111, 5, 1, 1, 0, 0, 0);
    vecs[6]  = mk(1, 4'b0011, 6, 1, 1, 0, 0, 0);
    vecs[7]  = mk(1, 4'b0001, 7, 1, 1, 0, 0, 0);
    vecs[8]  = mk(1, 4'b0000, 0, 1, 1, 0, 0, 0);
    vecs[9]  = mk(1, 4'b1000, 1, 1, 1, 0, 0, 0);
    vecs[10] = mk(1, 4'b1100, 2, 1, 1, 0, 0, 0);
    vecs[11] = mk(1, 4'b1111, 4, 1, 0, 0, 1, 1);
    vecs[12] = mk(1, 4'b0111, 5, 1, 0, 0, 0, 1);
    vecs[13] = mk(1, 4'b0011, 6, 1, 1, 0, 0, 1);
    vecs[14] = mk(1, 4'b1010, 6, 0, 0, 1, 0, 2);
    vecs[15] = mk(1, 4'b0011, 6, 1, 0, 0, 0, 2);
    vecs[16] = mk(1, 4'b0001, 7, 1, 0, 0, 0, 2);
    vecs[17] = mk(1, 4'b0000, 0, 1, 1, 0, 0, 2);
    vecs[18] = mk(1, 4'b1000, 1, 1, 1, 0, 0, 2);
    vecs[19] = mk(1, 4'b1100, 2, 1, 1, 0, 0, 2);
    vecs[20] = mk(1, 4'b1110, 3, 1, 1, 0, 0, 2);
    vecs[21] = mk(1, 4'b1110, 3, 1, 0, 0, 1, 3);
    for (int i = 22; i < 27; i++) vecs[i] = mk(0, 4'b1010, 3, 0, 0, 0, 0, 3);
    vecs[27] = mk(1, 4'b1111, 4, 1, 0, 0, 0, 3);

    rst_n        = 1'b0;
    bus.valid_in = 1'b0;
    bus.code_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", mk(0, 4'b0000, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;

    for (int i = 0; i < 28; i++) step($sformatf("vec%0d", i), vecs[i]);

    // Illegal words until the error counter saturates.
    exp_cnt = 3;
    for (int k = 0; k < 300; k++) begin
      if (exp_cnt < 255) exp_cnt++;
      step($sformatf("sat%0d", k),
           mk(1, bad[$urandom_range(0, 7)], 4, 0, 0, 1, 0, exp_cnt));
    end

    // Re-lock, then reset asynchronously between edges.
    step("relock0", mk(1, 4'b0111, 5, 1, 0, 0, 0, 255));
    step("relock1", mk(1, 4'b0011, 6, 1, 0, 0, 0, 255));
    step("relock2", mk(1, 4'b0001, 7, 1, 1, 0, 0, 255));
    bus.valid_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all("midrst", mk(0, 4'b0000, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    step("post0", mk(1, 4'b0011, 6, 1, 0, 0, 0, 0));
    step("post1", mk(1, 4'b0001, 7, 1, 0, 0, 0, 0));
    step("post2", mk(1, 4'b0000, 0, 1, 1, 0, 0, 0));

    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/johnson_checker.md
# johnson_checker

Receive-side checker for the team's WIDTH-bit Johnson (twisted-ring) counter sequence. It samples a Johnson code word and converts it to a binary state index. It detects illegal code words and out-of-sequence transitions, and reports lock status plus a saturating error count. It sits downstream of the Johnson counter generator, or of any link carrying its code, as the consumer/monitor end of that sequence.

## Interface
- WIDTH, 4: code width in bits; must be ≥ 2. Legal sequence length is 2*WIDTH.
- LOCK_CNT, 2: consecutive correct transitions required to declare lock; must be ≥ 1.
- IW (local), $clog2(2*WIDTH): index width.
- clk  input  1  single clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- code_in  input  WIDTH  Johnson code word under test.
- valid_in  input  1  code_in is sampled only on edges where valid_in=1.
- index  output  IW  decoded state index of the last legal sample; reset 0.
- index_valid  output  1  one-cycle pulse: index updated from a legal sample; reset 0.
- locked  output  1  sequence tracked for ≥ LOCK_CNT consecutive correct transitions; reset 0.
- err_code  output  1  one-cycle pulse: sampled word is not a legal Johnson code; reset 0.
- err_seq  output  1  one-cycle pulse: legal word but not the expected successor; reset 0.
- err_count  output  8  saturating count of err_code + err_seq events; reset 0.

## Operation
- Sequence definition: successor of code c is {~c[0], c[WIDTH-1:1]}. With WIDTH=4 the cycle is 0000→1000→1100→1110→1111→0111→0011→0001→0000.
- Legality: a word is legal when it has at most one position i (0..WIDTH-2) with code[i] ≠ code[i+1]. All other words are illegal.
- Index decode uses p = popcount(code).
  - If code[WIDTH-1]=1 or code=0, index = p.
  - Otherwise index = 2*WIDTH − p.
  - Range 0..2*WIDTH−1; e.g. 0111→5, 0001→7.
- State machine, states UNLOCKED, CHECK and LOCKED, with registered last-code prev and match counter mcnt:
  - UNLOCKED: a legal sample stores prev, sets mcnt=0 and goes to CHECK. An illegal sample raises err_code and stays.
  - CHECK: a sample equal to succ(prev) updates prev and increments mcnt. When mcnt reaches LOCK_CNT → LOCKED.
  - CHECK or LOCKED, legal sample ≠ succ(prev): err_seq, prev = sample, mcnt=0, state CHECK. This is re-acquisition from the new code.
  - LOCKED: an expected successor stays LOCKED.
  - Any state, illegal sample: err_code, state UNLOCKED, mcnt=0.
- locked = (state == LOCKED), registered.
- A repeated identical code (stall) is a sequence error, not a hold.
- Wrap-around 0001→0000 (index 7→0 for WIDTH=4) is a correct transition.
- valid_in=0: no state, prev, mcnt, index or error change; all pulses 0.
- Precedence: an illegal code raises only err_code, never err_seq. At most one error event per sample, so err_count increments by at most 1 per edge.
- err_count saturates at 255 and holds.

## Timing
- Latency: index, index_valid, err_code, err_seq and locked all update on the same clk edge that samples valid_in=1, i.e. they are visible one cycle after presentation.
- Pulses last exactly one cycle unless the next sample also qualifies.
- locked rises on the edge sampling the LOCK_CNT-th matching transition. It falls on the edge sampling the offending word.
- index holds its last legal value through idle cycles and illegal samples. index_valid is 0 on illegal samples.
- Reset asserted at any time, including mid-sequence, clears all outputs and internal state immediately and asynchronously. After release the first sample is treated as from UNLOCKED.

## Test plan
- Lock acquisition (WIDTH=4, LOCK_CNT=2): after reset, present 0000, 1000, 1100 on consecutive cycles with valid_in=1 → index 0, 1, 2 with index_valid=1. locked=1 on the edge sampling 1100. err_count=0.
- Full-cycle wrap: continue 1110…0001, 0000, 1000 → index 3..7, 0, 1. locked stays 1. No errors.
- Skip in LOCKED: from locked at 1100, present 1111 → err_seq=1, locked=0, index=4, err_count=1. Then 0111, 0011 → locked=1 again on 0011.
- Illegal word: present 1010 → err_code=1, err_seq=0, index_valid=0, index unchanged, locked=0, err_count incremented. The next legal 0011 enters CHECK with no error.
- Stall/idle: repeat 1110 twice with valid_in=1 → err_seq on the second sample. Hold valid_in=0 for 5 cycles → no output change. Drive 300 illegal samples → err_count saturates at 255.
- Reset mid-operation: assert rst_n=0 between clock edges while locked → locked, index, err_count and all pulses are 0 before the next edge. After release, 0011 alone does not lock.
